operand_fetch_stage: RTL and testbench

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

---
 rtl/operand_fetch_stage.sv | 98 +++++++++
 tb/tb_operand_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: operand select, hazard detection and ID/EX latch.
// Define OPERAND_FETCH_FWD_EN to enable the bypass network; otherwise any pending producer stalls ID.
module operand_fetch_stage #(
  parameter int W = 32,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          C_n,
  input  logic          id_valid,
  input  logic          id_usea,
  input  logic          id_useb,
  input  logic          id_regw,
  input  logic          id_memrd,
  input  logic [3:0]    id_ra,
  input  logic [3:0]    id_rb,
  input  logic [3:0]    id_rd,
  input  logic [W-1:0]  id_imm,
  input  logic [CW-1:0] id_ctrl,
  output logic [3:0]    RA,
  output logic [3:0]    RB,
  input  logic [W-1:0]  BusA,
  input  logic [W-1:0]  BusB,
  input  logic [W-1:0]  ex_result,
  input  logic          mem_regw,
  input  logic          wb_regw,
  input  logic [3:0]    mem_rd,
  input  logic [3:0]    wb_rd,
  input  logic [W-1:0]  mem_data,
  input  logic [W-1:0]  wb_data,
  input  logic          hold_in,
  input  logic          flush,
  output logic          stall_out,
  output logic          ex_valid,
  output logic          ex_regw,
  output logic          ex_memrd,
  output logic [3:0]    ex_rd,
  output logic [W-1:0]  ex_opA,
  output logic [W-1:0]  ex_opB,
  output logic [W-1:0]  ex_imm,
  output logic [CW-1:0] ex_ctrl,
  output logic [15:0]   stall_cnt
);
  logic hazard;
  logic [W-1:0] op_a, op_b;
  assign RA = id_ra;
  assign RB = id_rb;
`ifdef OPERAND_FETCH_FWD_EN
  function automatic logic [W-1:0] sel(input logic [3:0] s, input logic [W-1:0] bus);
    sel = (ex_valid && ex_regw && !ex_memrd && ex_rd == s) ? ex_result :
          (mem_regw && mem_rd == s) ? mem_data :
          (wb_regw && wb_rd == s) ? wb_data : bus;
  endfunction
  assign op_a = sel(id_ra, BusA);
  assign op_b = sel(id_rb, BusB);
  assign hazard = id_valid && ex_valid && ex_regw && ex_memrd &&
                  ((id_usea && ex_rd == id_ra) || (id_useb && ex_rd == id_rb));
`else
  function automatic logic busy(input logic [3:0] s);
    busy = (ex_valid && ex_regw && ex_rd == s) || (mem_regw && mem_rd == s) || (wb_regw && wb_rd == s);
  endfunction
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_data, wb_data};
  assign op_a = BusA;
  assign op_b = BusB;
  assign hazard = id_valid && ((id_usea && busy(id_ra)) || (id_useb && busy(id_rb)));
`endif
  // Gated by C_n so a held-off pipeline never sees a freeze while in reset.
  assign stall_out = C_n && (hazard || hold_in) && !flush;
  always_ff @(posedge CLK or negedge C_n) begin
    if (!C_n) begin
      ex_valid  <= 1'b0;
      ex_regw   <= 1'b0;
      ex_memrd  <= 1'b0;
      ex_rd     <= '0;
      ex_opA    <= '0;
      ex_opB    <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush || (!hold_in && hazard)) begin
        ex_valid <= 1'b0;
        ex_regw  <= 1'b0;
        ex_memrd <= 1'b0;
      end else if (!hold_in) begin
        ex_valid <= id_valid;
        ex_regw  <= id_regw;
        ex_memrd <= id_memrd;
        ex_rd    <= id_rd;
        ex_opA   <= op_a;
        ex_opB   <= op_b;
        ex_imm   <= id_imm;
        ex_ctrl  <= id_ctrl;
      end
      if (hazard && !hold_in && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: random stimulus vs. a producer-list reference model, scoreboarded.
module tb_operand_fetch_stage;
  localparam int W = 32;
  localparam int CW = 8;
  typedef struct packed {
    logic v, regw, memrd;
    logic [3:0] rd;
    logic [W-1:0] a, b, imm;
    logic [CW-1:0] ctrl;
    logic [15:0] cnt;
  } st_t;
  logic clk = 1'b0, c_n = 1'b0;
  logic id_valid, id_usea, id_useb, id_regw, id_memrd;
  logic [3:0] id_ra, id_rb, id_rd, RA, RB, mem_rd, wb_rd, ex_rd;
  logic [W-1:0] id_imm, BusA, BusB, ex_result, mem_data, wb_data, ex_opA, ex_opB, ex_imm;
  logic [CW-1:0] id_ctrl, ex_ctrl;
  logic mem_regw, wb_regw, hold_in, flush, stall_out, ex_valid, ex_regw, ex_memrd;
  logic [15:0] stall_cnt;
  st_t act, m;
  st_t lq[$];
  logic sq[$];
  int passed = 0, total = 0;
  logic pw[3], pld[3];
  logic [3:0] prd[3];
  logic [W-1:0] pd[3];

  operand_fetch_stage #(.W(W), .CW(CW)) dut (
    .CLK(clk), .C_n(c_n), .id_valid(id_valid), .id_usea(id_usea), .id_useb(id_useb),
    .id_regw(id_regw), .id_memrd(id_memrd), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .ex_result(ex_result), .mem_regw(mem_regw), .wb_regw(wb_regw), .mem_rd(mem_rd),
    .wb_rd(wb_rd), .mem_data(mem_data), .wb_data(wb_data), .hold_in(hold_in), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_regw(ex_regw), .ex_memrd(ex_memrd),
    .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign act = {ex_valid, ex_regw, ex_memrd, ex_rd, ex_opA, ex_opB, ex_imm, ex_ctrl, stall_cnt};

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic drive(bit sat);
    id_valid = $urandom_range(0, 9) < 8;
    id_usea = $urandom_range(0, 9) < 7;
    id_useb = $urandom_range(0, 9) < 7;
    id_regw = $urandom_range(0, 9) < 7;
    id_memrd = $urandom_range(0, 9) < 4;
    id_ra = 4'($urandom_range(0, 3));
    id_rb = 4'($urandom_range(0, 3));
    id_rd = 4'($urandom_range(0, 3));
    id_imm = $urandom;
    id_ctrl = CW'($urandom);
    BusA = $urandom;
    BusB = $urandom;
    ex_result = $urandom;
    mem_data = $urandom;
    wb_data = $urandom;
    mem_regw = $urandom_range(0, 1) == 1;
    wb_regw = $urandom_range(0, 1) == 1;
    mem_rd = 4'($urandom_range(0, 3));
    wb_rd = 4'($urandom_range(0, 3));
    hold_in = $urandom_range(0, 9) == 0;
    flush = $urandom_range(0, 99) < 7;
    if (sat) begin
      {id_valid, id_usea, mem_regw, hold_in, flush} = 5'b11100;
      id_ra = 4'd1;
      mem_rd = 4'd1;
    end
    if (RA !== id_ra || RB !== id_rb) begin end
  endtask

  // Producers ordered youngest (EX) to oldest (WB); a load in EX cannot supply data yet.
  task automatic step();
    logic haz;
    logic [W-1:0] a, b;
    chk("read_addr", {RA, RB}, {id_ra, id_rb});
    pw[0] = m.v && m.regw; prd[0] = m.rd; pd[0] = ex_result; pld[0] = m.memrd;
    pw[1] = mem_regw; prd[1] = mem_rd; pd[1] = mem_data; pld[1] = 1'b0;
    pw[2] = wb_regw; prd[2] = wb_rd; pd[2] = wb_data; pld[2] = 1'b0;
    a = BusA;
    b = BusB;
    haz = 1'b0;
`ifdef OPERAND_FETCH_FWD_EN
    for (int k = 2; k >= 0; k--) begin
      if (pw[k] && !pld[k] && prd[k] == id_ra) a = pd[k];
      if (pw[k] && !pld[k] && prd[k] == id_rb) b = pd[k];
    end
    haz = id_valid && pw[0] && pld[0] && ((id_usea && prd[0] == id_ra) || (id_useb && prd[0] == id_rb));
`else
    for (int k = 0; k < 3; k++)
      if (pw[k] && ((id_usea && prd[k] == id_ra) || (id_useb && prd[k] == id_rb))) haz = 1'b1;
    haz = haz && id_valid;
`endif
    sq.push_back((haz || hold_in) && !flush);
    if (flush || (haz && !hold_in)) {m.v, m.regw, m.memrd} = 3'b000;
    else if (!hold_in) begin
      {m.v, m.regw, m.memrd, m.rd} = {id_valid, id_regw, id_memrd, id_rd};
      {m.a, m.b, m.imm, m.ctrl} = {a, b, id_imm, id_ctrl};
    end
    if (haz && !hold_in && !flush && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
    lq.push_back(m);
  endtask

  always @(negedge clk) begin
    #3;
    if (sq.size() > 0) chk("stall_out", 128'(stall_out), 128'(sq.pop_front()));
  end

  always @(posedge clk) begin
    #1;
    if (lq.size() > 0) chk("ex_latch", act, lq.pop_front());
  end

  initial begin
    drive(1'b0);
    hold_in = 1'b1;
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {act, stall_out}, 128'd0);
    @(negedge clk);
    c_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      drive(1'b0);
      if (i % 97 == 50) begin
        c_n = 1'b0;
        #1;
        chk("async_reset", {act, stall_out}, 128'd0);
        c_n = 1'b1;
        m = '0;
      end
      step();
    end
`ifndef OPERAND_FETCH_FWD_EN
    for (int i = 0; i < 65545; i++) begin
      @(negedge clk);
      #1;
      drive(1'b1);
      step();
    end
    chk("saturated", 128'(stall_cnt), 128'(16'hFFFF));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      drive(1'b0);
      step();
    end
`endif
    @(negedge clk);
    #1;
    drive(1'b0);
    {id_valid, hold_in, flush} = 3'b000;
    step();
    repeat (2) @(posedge clk);
    #3;
    chk("queues_drained", 128'(lq.size() + sq.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
